// File: rtl/hatch_loader_pkg.sv
// Shared types and constants for the hatch instruction-memory loader.
package hatch_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_e;

   localparam int         BYTES_PER_INSN    = 6;
   localparam int         INSN_W            = 48;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/hatch_insn_assembler.sv
// Packs a big-endian byte stream into 48-bit instructions; word_valid_o marks the
// byte that completes a word, with word_o already holding the finished value.
module hatch_insn_assembler
   import hatch_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_b,
   input  logic              byte_strobe_i,
   input  logic              clear_i,
   input  logic [7:0]        byte_i,
   output logic [INSN_W-1:0] word_o,
   output logic              word_valid_o
);

   localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_INSN - 1);

   logic [INSN_W-1:0] shift_q;
   logic [2:0]        cnt_q;

   assign word_o       = {shift_q[INSN_W-9:0], byte_i};
   assign word_valid_o = byte_strobe_i && !clear_i && (cnt_q == LAST_BYTE);

   // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_b || clear_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (byte_strobe_i) begin
         shift_q <= word_o;
         cnt_q   <= (cnt_q == LAST_BYTE) ? 3'd0 : cnt_q + 3'd1;
      end
   end

endmodule

// File: rtl/hatch_loader.sv
// Framed byte-stream loader for the hatch instruction memory; holds the CPU in
// reset until a frame has been written and its checksum verified.
module hatch_loader
   import hatch_loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int         DEPTH          = 64,
   parameter int         ADDR_W         = 6,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [INSN_W-1:0] mem_wdata,
   output logic              cpu_rst_b,
   output logic              load_done,
   output logic              load_err
);

   localparam int              GAP_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
   localparam logic [8:0]       DEPTH_L  = 9'(DEPTH);

   state_e              state_q;
   logic                rx_ready_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [INSN_W-1:0]   mem_wdata_q;
   logic                cpu_rst_b_q;
   logic                load_done_q;
   logic                load_err_q;
   logic [7:0]          count_q;
   logic [7:0]          sum_q;
   logic [ADDR_W-1:0]   index_q;
   logic [GAP_W-1:0]    gap_q;

   logic                accept;
   logic                active;
   logic                timeout;
   logic [INSN_W-1:0]   asm_word;
   logic                asm_word_valid;

   assign accept  = rx_valid && rx_ready_q;
   assign active  = (state_q == COUNT) || (state_q == DATA) || (state_q == CSUM);
   // An arriving byte always beats the idle timeout on the same cycle.
   assign timeout = active && !accept && (gap_q == GAP_LAST);

   hatch_insn_assembler u_asm (
      .clk          (clk),
      .rst_b        (rst_b),
      .byte_strobe_i(accept && (state_q == DATA)),
      .clear_i      (state_q != DATA),
      .byte_i       (rx_data),
      .word_o       (asm_word),
      .word_valid_o (asm_word_valid)
   );

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q     <= IDLE;
         rx_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rst_b_q <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         count_q     <= '0;
         sum_q       <= '0;
         index_q     <= '0;
         gap_q       <= '0;
      end else begin
         rx_ready_q <= 1'b1;
         mem_we_q   <= 1'b0;
         gap_q      <= (accept || !active) ? '0 : gap_q + 1'b1;

         if (timeout) begin
            state_q     <= ERR;
            load_err_q  <= 1'b1;
            load_done_q <= 1'b0;
            cpu_rst_b_q <= 1'b0;
         end else if (accept) begin
            unique case (state_q)
               IDLE: if (rx_data == SYNC_BYTE) state_q <= COUNT;
               COUNT: begin
                  if ((rx_data == 8'd0) || ({1'b0, rx_data} > DEPTH_L)) begin
                     state_q    <= ERR;
                     load_err_q <= 1'b1;
                  end else begin
                     count_q <= rx_data;
                     sum_q   <= rx_data;
                     index_q <= '0;
                     state_q <= DATA;
                  end
               end
               DATA: begin
                  sum_q <= sum_q + rx_data;
                  if (asm_word_valid) begin
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= index_q;
                     mem_wdata_q <= asm_word;
                     index_q     <= index_q + 1'b1;
                     if (8'(index_q) == count_q - 8'd1) state_q <= CSUM;
                  end
               end
               CSUM: begin
                  if (rx_data == sum_q) begin
                     state_q     <= DONE;
                     load_done_q <= 1'b1;
                     load_err_q  <= 1'b0;
                     cpu_rst_b_q <= 1'b1;
                  end else begin
                     state_q    <= ERR;
                     load_err_q <= 1'b1;
                  end
               end
               DONE, ERR: begin
                  if (rx_data == SYNC_BYTE) begin
                     state_q     <= COUNT;
                     cpu_rst_b_q <= 1'b0;
                     load_done_q <= 1'b0;
                     load_err_q  <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign rx_ready  = rx_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rst_b = cpu_rst_b_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;

endmodule

// File: tb/tb_hatch_loader.sv
// Directed bench for hatch_loader: stimulus queues expected memory writes, a
// negedge monitor pops and compares them whenever mem_we is seen.
module tb_hatch_loader;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        mem_we;
   logic [5:0]  mem_addr;
   logic [47:0] mem_wdata;
   logic        cpu_rst_b;
   logic        load_done;
   logic        load_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0]  addr;
      logic [47:0] data;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] byte_q[$];

   always #5 clk = ~clk;

   hatch_loader #(
      .SYNC_BYTE     (8'hA5),
      .DEPTH         (64),
      .ADDR_W        (6),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_rst_b(cpu_rst_b),
      .load_done(load_done),
      .load_err (load_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic expect_write(input logic [5:0] addr, input logic [47:0] data);
      wr_t w;
      w.addr = addr;
      w.data = data;
      exp_q.push_back(w);
   endtask

   // Called just after a rising edge; the byte transfers on the next edge.
   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_q();
      foreach (byte_q[i]) send_byte(byte_q[i]);
      byte_q.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag, input logic done, input logic err, input logic cpu);
      check({tag, "_load_done"}, 64'(load_done), 64'(done));
      check({tag, "_load_err"}, 64'(load_err), 64'(err));
      check({tag, "_cpu_rst_b"}, 64'(cpu_rst_b), 64'(cpu));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
      check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
      check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
      check_status(tag, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_drained(input string tag);
      idle(2);
      check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   always @(negedge clk) begin
      if (mem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %h, expected no write", mem_addr, mem_wdata);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            check("wr_addr", 64'(mem_addr), 64'(w.addr));
            check("wr_data", 64'(mem_wdata), 64'(w.data));
         end
      end
   end

   initial begin
      rst_b    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(3);
      check_reset_outputs("reset");
      rst_b = 1'b1;
      idle(1);
      check("rx_ready_after_reset", 64'(rx_ready), 64'd1);

      // Happy path: 0x02 + 0x165 + 0x15 = 0x17C, so the checksum byte is 0x7C.
      expect_write(6'd0, 48'h112233445566);
      expect_write(6'd1, 48'h010203040506);
      byte_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h7C};
      send_q();
      idle(1);
      check_status("happy", 1'b1, 1'b0, 1'b1);
      check_drained("happy");

      // Bad checksum: writes still happen, then error with CPU held.
      expect_write(6'd0, 48'h112233445566);
      expect_write(6'd1, 48'h010203040506);
      byte_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h6C};
      send_q();
      idle(1);
      check_status("bad_csum", 1'b0, 1'b1, 1'b0);
      check_drained("bad_csum");

      // Bad counts: zero and DEPTH+1, no writes expected.
      send_byte(8'hA5);
      check_status("restart_from_err", 1'b0, 1'b0, 1'b0);
      send_byte(8'h00);
      check_status("count_zero", 1'b0, 1'b1, 1'b0);
      send_byte(8'hA5);
      send_byte(8'h41);
      check_status("count_65", 1'b0, 1'b1, 1'b0);
      check_drained("bad_count");

      // Timeout after a stall well past 16 idle cycles.
      byte_q = '{8'hA5, 8'h01, 8'hAA};
      send_q();
      check_status("pre_timeout", 1'b0, 1'b0, 1'b0);
      idle(20);
      check_status("timeout", 1'b0, 1'b1, 1'b0);
      check_drained("timeout");

      // Byte arriving on the exact timeout cycle wins; sum 0x4FC -> 0xFC.
      expect_write(6'd0, 48'hAABBCCDDEEFF);
      byte_q = '{8'hA5, 8'h01, 8'hAA};
      send_q();
      idle(15);
      send_byte(8'hBB);
      check_status("edge_byte", 1'b0, 1'b0, 1'b0);
      byte_q = '{8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hFC};
      send_q();
      idle(1);
      check_status("edge_done", 1'b1, 1'b0, 1'b1);
      check_drained("timeout_edge");

      // Noise in DONE is ignored; sync drops cpu_rst_b at once. Sum 0x33A -> 0x3A.
      byte_q = '{8'h00, 8'hFF};
      send_q();
      check_status("done_noise", 1'b1, 1'b0, 1'b1);
      send_byte(8'hA5);
      check_status("reload_sync", 1'b0, 1'b0, 1'b0);
      expect_write(6'd0, 48'hDEADBEEF0001);
      byte_q = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h01, 8'h3A};
      send_q();
      idle(1);
      check_status("reload_done", 1'b1, 1'b0, 1'b1);
      check_drained("reload");

      // Reset mid-frame after three data bytes.
      byte_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33};
      send_q();
      rst_b = 1'b0;
      idle(1);
      check_reset_outputs("mid_reset");
      rst_b = 1'b1;
      idle(1);

      // Noise in IDLE, then a clean frame: sum 0x387 -> 0x87.
      expect_write(6'd0, 48'hCAFEBABE1234);
      byte_q = '{8'h00, 8'h5A, 8'hFF, 8'h13,
                 8'hA5, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h12, 8'h34, 8'h87};
      send_q();
      idle(1);
      check_status("after_reset", 1'b1, 1'b0, 1'b1);
      check_drained("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
